ram_port_arbiter: RTL and testbench

Single-clock arbiter sharing one 8x16 dual-port RAM (one write port, one read port) between two requesters, A and B. Each requester issues single-word reads or writes through a req/gnt handshake. Reads return data a fixed two cycles after grant. A write and a read from different requesters are granted in the same cycle when they target different addresses. The block sits between the client logic and the RAM, and drives all RAM write and read port signals with both RAM clocks tied to `clk`.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 51 +++++
 rtl/ram_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-requester RAM port arbiter: default RAM
// geometry, requester identifiers and the read-return owner tag.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

    // Default RAM geometry: 8 words of 16 bits.
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 16;

    // Requester identifiers, also used as the grant-vector bit index.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // One slot of the read-return pipeline: is a read in flight, and whose.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Holds the priority pointer. When both
// requesters want the same RAM port, the pointer holder wins and the pointer
// moves to the loser. Without contention every valid requester is granted
// and the pointer stays put.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous active-high reset; forces grants low
//   i_valid    [0]=A, [1]=B requests eligible for a grant this cycle
//   i_conflict both requests target the same RAM port
//   o_gnt      grant vector, [0]=A, [1]=B (combinational)
// ---------------------------------------------------------------------------
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_conflict,
    output logic [1:0] o_gnt
);

    logic r_prio;
    logic w_prio_flip;

    // Grant selection and pointer update decision
    always_comb begin
        o_gnt       = 2'b00;
        w_prio_flip = 1'b0;
        if (!i_rst) begin
            if (i_conflict && (&i_valid)) begin
                o_gnt       = (r_prio == REQ_A) ? 2'b01 : 2'b10;
                w_prio_flip = 1'b1;
            end else begin
                o_gnt = i_valid;
            end
        end
    end

    // Priority pointer; after a contended grant it points at the loser
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prio <= REQ_A;
        end else if (w_prio_flip) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one dual-port RAM (one write port, one read port, both clocked by
// i_clk) between requesters A and B. Writes drive the RAM write port in the
// grant cycle. Reads drive the RAM read address in the grant cycle, and a
// two-slot owner tag pipeline steers the returned word to the owner's rdata
// register, so rvalid/rdata appear two cycles after the grant.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_{a,b}_req/we/addr/wdata    requester command, held until granted
//   o_{a,b}_gnt                  request accepted this cycle (combinational)
//   o_{a,b}_rvalid               one-cycle read-return pulse
//   o_{a,b}_rdata                last read data returned to that requester
//   o_ram_wr_en/addr/data        RAM write port
//   o_ram_rd_addr                RAM read address
//   i_ram_rd_data                RAM read data, valid the cycle after address
// ---------------------------------------------------------------------------
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ram_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = ram_arb_pkg::DEF_DATA_W
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_req,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    input  logic              i_b_req,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic              o_a_gnt,
    output logic              o_b_gnt,
    output logic              o_a_rvalid,
    output logic              o_b_rvalid,
    output logic [DATA_W-1:0] o_a_rdata,
    output logic [DATA_W-1:0] o_b_rdata,
    output logic              o_ram_wr_en,
    output logic [ADDR_W-1:0] o_ram_wr_addr,
    output logic [DATA_W-1:0] o_ram_wr_data,
    output logic [ADDR_W-1:0] o_ram_rd_addr,
    input  logic [DATA_W-1:0] i_ram_rd_data
);

    logic              w_both;
    logic              w_same_addr;
    logic              w_mixed;
    logic              w_a_held;
    logic              w_b_held;
    logic [1:0]        w_valid;
    logic              w_conflict;
    logic [1:0]        w_gnt;
    logic              w_a_wr;
    logic              w_b_wr;
    logic              w_a_rd;
    logic              w_b_rd;
    logic [ADDR_W-1:0] w_rd_addr;
    rd_tag_t           w_push;

    logic [ADDR_W-1:0] r_rd_addr;
    rd_tag_t           r_tag0;
    rd_tag_t           r_tag1;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    // A write and a read to the same word: hold the read back one cycle so
    // it observes the freshly committed data instead of the stale word.
    // Two commands of the same kind contend for one port and go to rr_arb2.
    always_comb begin
        w_both      = i_a_req & i_b_req;
        w_same_addr = (i_a_addr == i_b_addr);
        w_mixed     = w_both & (i_a_we != i_b_we);
        w_a_held    = w_mixed & ~i_a_we & w_same_addr;
        w_b_held    = w_mixed & ~i_b_we & w_same_addr;
        w_valid     = {i_b_req & ~w_b_held, i_a_req & ~w_a_held};
        w_conflict  = w_both & (i_a_we == i_b_we);
    end

    rr_arb2 u_rr_arb2 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (w_valid),
        .i_conflict (w_conflict),
        .o_gnt      (w_gnt)
    );

    assign o_a_gnt = w_gnt[REQ_A];
    assign o_b_gnt = w_gnt[REQ_B];

    // RAM port muxing. At most one granted write and one granted read exist
    // in any cycle. With no read granted the read address keeps its last value.
    always_comb begin
        w_a_wr        = w_gnt[REQ_A] & i_a_we;
        w_b_wr        = w_gnt[REQ_B] & i_b_we;
        w_a_rd        = w_gnt[REQ_A] & ~i_a_we;
        w_b_rd        = w_gnt[REQ_B] & ~i_b_we;
        o_ram_wr_en   = w_a_wr | w_b_wr;
        o_ram_wr_addr = w_b_wr ? i_b_addr  : i_a_addr;
        o_ram_wr_data = w_b_wr ? i_b_wdata : i_a_wdata;
        w_rd_addr     = r_rd_addr;
        if (w_a_rd) begin
            w_rd_addr = i_a_addr;
        end else if (w_b_rd) begin
            w_rd_addr = i_b_addr;
        end
        w_push.valid  = w_a_rd | w_b_rd;
        w_push.id     = w_b_rd ? REQ_B : REQ_A;
    end

    assign o_ram_rd_addr = w_rd_addr;

    // Read address hold register and owner tag pipeline. Slot 0 tracks the
    // cycle the RAM presents data, slot 1 the cycle the return is visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_addr <= '0;
            r_tag0    <= '0;
            r_tag1    <= '0;
        end else begin
            r_rd_addr <= w_rd_addr;
            r_tag0    <= w_push;
            r_tag1    <= r_tag0;
        end
    end

    // Capture returning RAM data into the owner's register only
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else if (r_tag0.valid) begin
            if (r_tag0.id == REQ_A) begin
                r_a_rdata <= i_ram_rd_data;
            end else begin
                r_b_rdata <= i_ram_rd_data;
            end
        end
    end

    assign o_a_rvalid = r_tag1.valid & (r_tag1.id == REQ_A);
    assign o_b_rvalid = r_tag1.valid & (r_tag1.id == REQ_B);
    assign o_a_rdata  = r_a_rdata;
    assign o_b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter with a behavioural 8x16 RAM attached
// (write on the clock edge, registered read).
// ---------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        aReq, bReq, aWe, bWe;
    logic [2:0]  aAddr, bAddr;
    logic [15:0] aWdata, bWdata;
    logic        aGnt, bGnt, aRvalid, bRvalid;
    logic [15:0] aRdata, bRdata;
    logic        ramWrEn;
    logic [2:0]  ramWrAddr, ramRdAddr;
    logic [15:0] ramWrData, ramRdData;
    logic [15:0] mem [8];

    int testsRun    = 0;
    int testsFailed = 0;

    ram_port_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_a_req       (aReq),
        .i_a_we        (aWe),
        .i_a_addr      (aAddr),
        .i_a_wdata     (aWdata),
        .i_b_req       (bReq),
        .i_b_we        (bWe),
        .i_b_addr      (bAddr),
        .i_b_wdata     (bWdata),
        .o_a_gnt       (aGnt),
        .o_b_gnt       (bGnt),
        .o_a_rvalid    (aRvalid),
        .o_b_rvalid    (bRvalid),
        .o_a_rdata     (aRdata),
        .o_b_rdata     (bRdata),
        .o_ram_wr_en   (ramWrEn),
        .o_ram_wr_addr (ramWrAddr),
        .o_ram_wr_data (ramWrData),
        .o_ram_rd_addr (ramRdAddr),
        .i_ram_rd_data (ramRdData)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: commit on the edge, registered read data
    always @(posedge clk) begin
        if (ramWrEn) mem[ramWrAddr] <= ramWrData;
        ramRdData <= mem[ramRdAddr];
    end

    // Absolute time bound on the whole run
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    task nextCycle;
        @(posedge clk);
        #1;
    endtask

    task clearReqs;
        aReq = 0; bReq = 0; aWe = 0; bWe = 0;
        aAddr = 0; bAddr = 0; aWdata = 0; bWdata = 0;
    endtask

    task applyReset;
        clearReqs();
        rst = 1;
        nextCycle();
        nextCycle();
        rst = 0;
    endtask

    task test_reset;
        rst = 1;
        aReq = 1; aWe = 1; aAddr = 1; aWdata = 16'hFFFF;
        bReq = 1; bWe = 0; bAddr = 2;
        nextCycle();
        #1;
        testsRun++; if (aGnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_a_gnt: got %b expected 0", aGnt); end
        testsRun++; if (bGnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_b_gnt: got %b expected 0", bGnt); end
        testsRun++; if (ramWrEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_wr_en: got %b expected 0", ramWrEn); end
        nextCycle();
        testsRun++; if (aRvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_a_rvalid: got %b expected 0", aRvalid); end
        testsRun++; if (bRvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_b_rvalid: got %b expected 0", bRvalid); end
        testsRun++; if (aRdata !== 16'h0) begin testsFailed++; $display("[TB] FAIL rst_a_rdata: got %h expected 0000", aRdata); end
        testsRun++; if (bRdata !== 16'h0) begin testsFailed++; $display("[TB] FAIL rst_b_rdata: got %h expected 0000", bRdata); end
        clearReqs();
        rst = 0;
    endtask

    task test_single_writer;
        logic [15:0] d [3];
        d[0] = 16'hA1A1; d[1] = 16'hB2B2; d[2] = 16'hC3C3;
        for (int k = 0; k < 3; k++) begin
            aReq = 1; aWe = 1; aAddr = 3'(k); aWdata = d[k];
            #1;
            testsRun++; if (aGnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL sw_wr_gnt[%0d]: got %b expected 1", k, aGnt); end
            testsRun++; if (ramWrEn !== 1'b1 || ramWrAddr !== 3'(k) || ramWrData !== d[k]) begin testsFailed++; $display("[TB] FAIL sw_wr_port[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h", k, ramWrEn, ramWrAddr, ramWrData, k, d[k]); end
            nextCycle();
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                aReq = 1; aWe = 0; aAddr = 3'(k);
            end else begin
                clearReqs();
            end
            #1;
            if (k < 3) begin
                testsRun++; if (aGnt !== 1'b1 || ramRdAddr !== 3'(k)) begin testsFailed++; $display("[TB] FAIL sw_rd_gnt[%0d]: got gnt=%b addr=%0d expected gnt=1 addr=%0d", k, aGnt, ramRdAddr, k); end
            end
            testsRun++; if (aRvalid !== (k >= 2)) begin testsFailed++; $display("[TB] FAIL sw_rvalid[%0d]: got %b expected %b", k, aRvalid, (k >= 2)); end
            testsRun++; if (bRvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL sw_b_rvalid[%0d]: got %b expected 0", k, bRvalid); end
            if (k >= 2) begin
                testsRun++; if (aRdata !== d[k-2]) begin testsFailed++; $display("[TB] FAIL sw_rdata[%0d]: got %h expected %h", k, aRdata, d[k-2]); end
            end
            nextCycle();
        end
    endtask

    task test_write_contention;
        applyReset();
        aReq = 1; aWe = 1; aAddr = 5; aWdata = 16'h5A5A;
        bReq = 1; bWe = 1; bAddr = 5; bWdata = 16'h5B5B;
        #1;
        testsRun++; if (aGnt !== 1'b1 || bGnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL ww_first: got a=%b b=%b expected a=1 b=0", aGnt, bGnt); end
        testsRun++; if (ramWrData !== 16'h5A5A) begin testsFailed++; $display("[TB] FAIL ww_first_data: got %h expected 5a5a", ramWrData); end
        nextCycle();
        aReq = 0;
        #1;
        testsRun++; if (bGnt !== 1'b1 || ramWrAddr !== 3'd5 || ramWrData !== 16'h5B5B) begin testsFailed++; $display("[TB] FAIL ww_second: got gnt=%b addr=%0d data=%h expected gnt=1 addr=5 data=5b5b", bGnt, ramWrAddr, ramWrData); end
        nextCycle();
        // Pointer now at B: a new write contention must go to B
        aReq = 1; aWe = 1; aAddr = 7; aWdata = 16'h7A7A;
        bReq = 1; bWe = 1; bAddr = 7; bWdata = 16'h7B7B;
        #1;
        testsRun++; if (aGnt !== 1'b0 || bGnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL ww_prio_b: got a=%b b=%b expected a=0 b=1", aGnt, bGnt); end
        nextCycle();
        bReq = 0;
        #1;
        testsRun++; if (aGnt !== 1'b1 || ramWrData !== 16'h7A7A) begin testsFailed++; $display("[TB] FAIL ww_a_after: got gnt=%b data=%h expected gnt=1 data=7a7a", aGnt, ramWrData); end
        nextCycle();
        clearReqs();
        aReq = 1; aWe = 0; aAddr = 5;
        #1;
        testsRun++; if (aGnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL ww_rd_gnt: got %b expected 1", aGnt); end
        nextCycle();
        clearReqs();
        nextCycle();
        testsRun++; if (aRvalid !== 1'b1 || aRdata !== 16'h5B5B) begin testsFailed++; $display("[TB] FAIL ww_final_read: got v=%b data=%h expected v=1 data=5b5b", aRvalid, aRdata); end
        nextCycle();
    endtask

    task test_parallel_write_read;
        clearReqs();
        bReq = 1; bWe = 1; bAddr = 4; bWdata = 16'hE5E5;
        #1;
        testsRun++; if (bGnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL pw_preload: got %b expected 1", bGnt); end
        nextCycle();
        aReq = 1; aWe = 1; aAddr = 3; aWdata = 16'hD4D4;
        bReq = 1; bWe = 0; bAddr = 4;
        #1;
        testsRun++; if (aGnt !== 1'b1 || bGnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL pw_both_gnt: got a=%b b=%b expected a=1 b=1", aGnt, bGnt); end
        testsRun++; if (ramWrAddr !== 3'd3 || ramRdAddr !== 3'd4) begin testsFailed++; $display("[TB] FAIL pw_ports: got wa=%0d ra=%0d expected wa=3 ra=4", ramWrAddr, ramRdAddr); end
        nextCycle();
        clearReqs();
        #1;
        testsRun++; if (bRvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL pw_early_rvalid: got %b expected 0", bRvalid); end
        nextCycle();
        testsRun++; if (bRvalid !== 1'b1 || bRdata !== 16'hE5E5) begin testsFailed++; $display("[TB] FAIL pw_b_read: got v=%b data=%h expected v=1 data=e5e5", bRvalid, bRdata); end
        testsRun++; if (aRvalid !== 1'b0) begin testsFailed++; $display("[TB] FAIL pw_a_rvalid: got %b expected 0", aRvalid); end
        testsRun++; if (mem[3] !== 16'hD4D4) begin testsFailed++; $display("[TB] FAIL pw_write_commit: got %h expected d4d4", mem[3]); end
        nextCycle();
    endtask

    task test_same_addr_hazard;
        aReq = 1; aWe = 1; aAddr = 6; aWdata = 16'h1234;
        bReq = 1; bWe = 0; bAddr = 6;
        #1;
        testsRun++; if (aGnt !== 1'b1 || bGnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL hz_first: got a=%b b=%b expected a=1 b=0", aGnt, bGnt); end
        testsRun++; if (ramRdAddr !== 3'd4) begin testsFailed++; $display("[TB] FAIL hz_rd_addr_hold: got %0d expected 4", ramRdAddr); end
        nextCycle();
        aReq = 0;
        #1;
        testsRun++; if (bGnt !== 1'b1 || ramRdAddr !== 3'd6) begin testsFailed++; $display("[TB] FAIL hz_second: got gnt=%b addr=%0d expected gnt=1 addr=6", bGnt, ramRdAddr); end
        nextCycle();
        clearReqs();
        nextCycle();
        testsRun++; if (bRvalid !== 1'b1 || bRdata !== 16'h1234) begin testsFailed++; $display("[TB] FAIL hz_read: got v=%b data=%h expected v=1 data=1234", bRvalid, bRdata); end
        nextCycle();
    endtask

    task test_read_alternation;
        logic expA;
        applyReset();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                aReq = 1; aWe = 0; aAddr = 0;
                bReq = 1; bWe = 0; bAddr = 2;
            end else begin
                clearReqs();
            end
            #1;
            if (k < 6) begin
                testsRun++; if (aGnt !== (k % 2 == 0) || bGnt !== (k % 2 == 1)) begin testsFailed++; $display("[TB] FAIL rr_gnt[%0d]: got a=%b b=%b expected a=%b b=%b", k, aGnt, bGnt, (k % 2 == 0), (k % 2 == 1)); end
            end
            if (k >= 2) begin
                expA = ((k - 2) % 2 == 0);
                testsRun++; if (aRvalid !== expA || bRvalid !== !expA) begin testsFailed++; $display("[TB] FAIL rr_rvalid[%0d]: got a=%b b=%b expected a=%b b=%b", k, aRvalid, bRvalid, expA, !expA); end
                if (expA) begin
                    testsRun++; if (aRdata !== 16'hA1A1) begin testsFailed++; $display("[TB] FAIL rr_a_rdata[%0d]: got %h expected a1a1", k, aRdata); end
                end else begin
                    testsRun++; if (bRdata !== 16'hC3C3) begin testsFailed++; $display("[TB] FAIL rr_b_rdata[%0d]: got %h expected c3c3", k, bRdata); end
                end
            end
            nextCycle();
        end
    endtask

    task test_reset_mid_read;
        clearReqs();
        aReq = 1; aWe = 0; aAddr = 2;
        #1;
        testsRun++; if (aGnt !== 1'b1) begin testsFailed++; $display("[TB] FAIL rm_gnt: got %b expected 1", aGnt); end
        nextCycle();
        clearReqs();
        rst = 1;
        nextCycle();
        rst = 0;
        for (int k = 0; k < 2; k++) begin
            #1;
            testsRun++; if (aRvalid !== 1'b0 || aRdata !== 16'h0) begin testsFailed++; $display("[TB] FAIL rm_discard[%0d]: got v=%b data=%h expected v=0 data=0000", k, aRvalid, aRdata); end
            nextCycle();
        end
        aReq = 1; aWe = 1; aAddr = 1; aWdata = 16'hB2B2;
        bReq = 1; bWe = 1; bAddr = 1; bWdata = 16'h0000;
        #1;
        testsRun++; if (aGnt !== 1'b1 || bGnt !== 1'b0) begin testsFailed++; $display("[TB] FAIL rm_prio_a: got a=%b b=%b expected a=1 b=0", aGnt, bGnt); end
        nextCycle();
        clearReqs();
    endtask

    initial begin
        clearReqs();
        rst = 1;
        test_reset();
        test_single_writer();
        test_write_contention();
        test_parallel_write_read();
        test_same_addr_hazard();
        test_read_alternation();
        test_reset_mid_read();
        nextCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
